pc_update: RTL and testbench

//  Sequential PC and processor-status stage of the Y86-64 SEQ core. It holds
//  the architectural PC that drives fetch. Each committed step it selects the

---
 rtl/pc_update.sv | 94 +++++++++
 tb/tb_pc_update.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/pc_update.sv
// Y86-64 SEQ PC and processor-status stage: next-PC select, status tracking, halt/fault freeze.
// Optional retire counter enabled by defining RETIRE_CNT_EN.
module pc_update #(
    parameter logic [63:0] RESET_PC = 64'd0
`ifdef RETIRE_CNT_EN
    , parameter int unsigned CNT_W = 32
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step_en,
    input  logic [3:0]  icode,
    input  logic        cnd,
    input  logic [63:0] valC,
    input  logic [63:0] valM,
    input  logic [63:0] valP,
    input  logic        instr_valid,
    input  logic        imem_error,
    input  logic        dmem_error,
    output logic [63:0] pc,
    output logic [2:0]  stat,
    output logic        halted
`ifdef RETIRE_CNT_EN
    , output logic [CNT_W-1:0] retired
`endif
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    state_t      state;
    logic [63:0] new_pc;
    logic        commit;

    always_comb begin
        new_pc = valP;
        unique case (icode)
            4'h7:    new_pc = cnd ? valC : valP;
            4'h8:    new_pc = valC;
            4'h9:    new_pc = valM;
            default: new_pc = valP;
        endcase
    end

    // A commit is any RUN step that is not a fault (halt or normal instruction).
    assign commit = step_en && (state == RUN) && !imem_error && instr_valid && !dmem_error;
    assign halted = (state != RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc    <= RESET_PC;
            stat  <= STAT_AOK;
            state <= RUN;
        end else if (step_en && state == RUN) begin
            if (imem_error) begin
                stat  <= STAT_ADR;
                state <= FAULT;
            end else if (!instr_valid) begin
                stat  <= STAT_INS;
                state <= FAULT;
            end else if (dmem_error) begin
                stat  <= STAT_ADR;
                state <= FAULT;
            end else if (icode == 4'h0) begin
                stat  <= STAT_HLT;
                state <= HALT;
            end else begin
                pc <= new_pc;
            end
        end
    end

`ifdef RETIRE_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired <= '0;
        end else if (commit && retired != '1) begin
            retired <= retired + 1'b1;
        end
    end
`else
    logic unused_commit;
    assign unused_commit = commit;
`endif

endmodule

// File: tb/tb_pc_update.sv
// Randomized self-checking bench for pc_update against a status-code level reference model.
// Covers RETIRE_CNT_EN when defined, including a CNT_W=2 saturating instance.
module tb_pc_update;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        step_en = 1'b0;
    logic [3:0]  icode = '0;
    logic        cnd = 1'b0;
    logic [63:0] valC = '0, valM = '0, valP = '0;
    logic        instr_valid = 1'b1;
    logic        imem_error = 1'b0;
    logic        dmem_error = 1'b0;
    logic [63:0] pc;
    logic [2:0]  stat;
    logic        halted;
`ifdef RETIRE_CNT_EN
    logic [31:0] retired;
    logic [63:0] pc_s;
    logic [2:0]  stat_s;
    logic        halted_s;
    logic [1:0]  retired_s;
`endif

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    // Reference state: PC, status code and count of committed instructions.
    logic [63:0] m_pc;
    int unsigned m_stat;
    longint unsigned m_cnt;

    always #5 clk = ~clk;

    pc_update u_dut (
        .clk(clk), .rst(rst), .step_en(step_en), .icode(icode), .cnd(cnd),
        .valC(valC), .valM(valM), .valP(valP), .instr_valid(instr_valid),
        .imem_error(imem_error), .dmem_error(dmem_error),
        .pc(pc), .stat(stat), .halted(halted)
`ifdef RETIRE_CNT_EN
        , .retired(retired)
`endif
    );

`ifdef RETIRE_CNT_EN
    pc_update #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .step_en(step_en), .icode(icode), .cnd(cnd),
        .valC(valC), .valM(valM), .valP(valP), .instr_valid(instr_valid),
        .imem_error(imem_error), .dmem_error(dmem_error),
        .pc(pc_s), .stat(stat_s), .halted(halted_s), .retired(retired_s)
    );
`endif

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string where);
        check({where, ".pc"}, pc, m_pc);
        check({where, ".stat"}, {61'd0, stat}, 64'(m_stat));
        check({where, ".halted"}, {63'd0, halted}, {63'd0, (m_stat != 1)});
`ifdef RETIRE_CNT_EN
        check({where, ".retired"}, {32'd0, retired}, m_cnt);
        check({where, ".retired_sat"}, {62'd0, retired_s}, (m_cnt > 3) ? 64'd3 : m_cnt);
        check({where, ".sat_pc"}, pc_s, m_pc);
`endif
    endtask

    // Asynchronous reset pulse placed mid-cycle, away from any clock edge.
    task automatic do_reset(input string where);
        @(negedge clk);
        rst = 1'b1;
        #1;
        m_pc = '0; m_stat = 1; m_cnt = 0;
        check_all(where);
        #2 rst = 1'b0;
    endtask

    task automatic step(input string where, input logic se, input logic [3:0] ic, input logic c,
                        input logic [63:0] vc, input logic [63:0] vm, input logic [63:0] vp,
                        input logic iv, input logic ie, input logic de);
        step_en = se; icode = ic; cnd = c; valC = vc; valM = vm; valP = vp;
        instr_valid = iv; imem_error = ie; dmem_error = de;
        @(posedge clk);
        if (se && m_stat == 1) begin
            if (ie)              m_stat = 3;
            else if (!iv)        m_stat = 4;
            else if (de)         m_stat = 3;
            else if (ic == 4'h0) begin m_stat = 2; m_cnt++; end
            else begin
                m_cnt++;
                if (ic == 4'h8)      m_pc = vc;
                else if (ic == 4'h7) m_pc = c ? vc : vp;
                else if (ic == 4'h9) m_pc = vm;
                else                 m_pc = vp;
            end
        end
        #1;
        check_all(where);
    endtask

    function automatic logic [63:0] r64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        m_pc = '0; m_stat = 1; m_cnt = 0;
        #2 rst = 1'b0;
        do_reset("reset");

        step("irmov", 1, 4'h6, 0, 64'h0, 64'h0, 64'h2A, 1, 0, 0);
        step("jnt", 1, 4'h7, 0, 64'h100, 64'h0, 64'h33, 1, 0, 0);
        step("jt", 1, 4'h7, 1, 64'h100, 64'h0, 64'h3C, 1, 0, 0);
        step("call", 1, 4'h8, 0, 64'h200, 64'h0, 64'h109, 1, 0, 0);
        step("ret", 1, 4'h9, 0, 64'h0, 64'h10A, 64'h201, 1, 0, 0);
        step("idle", 0, 4'h8, 0, 64'hDEAD, 64'h0, 64'h0, 1, 0, 0);
        step("to40", 1, 4'h6, 0, 64'h0, 64'h0, 64'h40, 1, 0, 0);
        step("halt", 1, 4'h0, 0, 64'h0, 64'h0, 64'h41, 1, 0, 0);
        for (int i = 0; i < 4; i++)
            step("frozen_h", 1, 4'($urandom), 1'($urandom), r64(), r64(), r64(),
                 1'($urandom), 1'($urandom), 1'($urandom));

        do_reset("rst2");
        step("adr_prio", 1, 4'h6, 0, 64'h0, 64'h0, 64'h8, 0, 1, 0);
        step("frozen_f", 1, 4'h6, 0, 64'h0, 64'h0, 64'h8, 1, 0, 0);
        do_reset("rst3");
        step("ins", 1, 4'h6, 0, 64'h0, 64'h0, 64'h8, 0, 0, 0);
        do_reset("rst4");
        step("pre_dmem", 1, 4'h6, 0, 64'h0, 64'h0, 64'h18, 1, 0, 0);
        step("dmem", 1, 4'h9, 0, 64'h0, 64'h77, 64'h20, 1, 0, 1);

        do_reset("rst5");
        for (int i = 0; i < 2000; i++) begin
            logic [3:0] ic;
            ic = 4'($urandom_range(1, 11));
            if ($urandom_range(0, 39) == 0) ic = 4'h0;
            step("rand", ($urandom_range(0, 4) != 0), ic, 1'($urandom), r64(), r64(), r64(),
                 ($urandom_range(0, 49) != 0), ($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 59) == 0));
            if (m_stat != 1 && $urandom_range(0, 3) == 0) do_reset("rand_rst");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
